// File: rtl/apb4_slave_regbank_if.sv
// APB4 completer bus bundle for the SNN configuration register bank.
// Carries the requester-driven request signals and the completer response.
interface apb4_slave_regbank_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb4_slave_regbank.sv
// APB4 completer holding the control/status register bank of the SNN core.
// SETUP captures the request and its decode; WAIT burns WAIT_STATES enabled
// ACCESS cycles; DONE drives a registered pready for one cycle and commits
// legal writes on the edge that ends it.
// Optional feature: define APB_SLVERR_EN to flag illegal accesses
// (misaligned, out-of-range, write to read-only) with pslverr in DONE.
module apb4_slave_regbank #(
    parameter int unsigned         ADDR_W      = 32,
    parameter int unsigned         DATA_W      = 32,
    parameter int unsigned         NUM_REGS    = 16,
    parameter int unsigned         WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    apb4_slave_regbank_if.slave          apb,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          reg_wr_pulse,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_status
);
    localparam int unsigned       STRB_W   = DATA_W / 8;
    localparam int unsigned       LSB      = $clog2(STRB_W);
    localparam int unsigned       IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'((64'd1 << LSB) - 64'd1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic [IDX_W-1:0]   cap_idx;
    logic               cap_write;
    logic               cap_err;
    logic [DATA_W-1:0]  cap_wdata;
    logic [STRB_W-1:0]  cap_strb;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    logic [ADDR_W-1:0]  word_l;
    logic [IDX_W-1:0]   idx_l;
    logic               err_l;
    logic [DATA_W-1:0]  rd_live;
    logic [DATA_W-1:0]  rd_cap;

    // Decode of the address currently on the bus (used at SETUP).
    always_comb begin
        word_l = apb.paddr >> LSB;
        idx_l  = word_l[IDX_W-1:0];
        err_l  = 1'b0;
        if ((apb.paddr & LSB_MASK) != '0) begin
            err_l = 1'b1;
        end
        if (word_l >= ADDR_W'(NUM_REGS)) begin
            err_l = 1'b1;
        end else if (apb.pwrite && RO_MASK[idx_l]) begin
            err_l = 1'b1;
        end
    end

    // Read data for DONE: live decode when SETUP jumps straight to DONE,
    // captured decode when leaving WAIT. Writes and illegal accesses read 0.
    always_comb begin
        rd_live = '0;
        rd_cap  = '0;
        if (!err_l && !apb.pwrite) begin
            rd_live = RO_MASK[idx_l] ? hw_status[idx_l*DATA_W +: DATA_W] : regs[idx_l];
        end
        if (!cap_err && !cap_write) begin
            rd_cap = RO_MASK[cap_idx] ? hw_status[cap_idx*DATA_W +: DATA_W] : regs[cap_idx];
        end
    end

    // Transfer FSM with registered pready/prdata/pslverr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cap_idx     <= '0;
            cap_write   <= 1'b0;
            cap_err     <= 1'b0;
            cap_wdata   <= '0;
            cap_strb    <= '0;
            apb.pready  <= 1'b0;
            apb.prdata  <= '0;
`ifdef APB_SLVERR_EN
            apb.pslverr <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (apb.psel && !apb.penable) begin
                        cap_idx   <= idx_l;
                        cap_write <= apb.pwrite;
                        cap_err   <= err_l;
                        cap_wdata <= apb.pwdata;
                        cap_strb  <= apb.pstrb;
                        if (WAIT_STATES == 0) begin
                            state       <= DONE;
                            apb.pready  <= 1'b1;
                            apb.prdata  <= rd_live;
`ifdef APB_SLVERR_EN
                            apb.pslverr <= err_l;
`endif
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_STATES);
                        end
                    end
                end
                WAIT: begin
                    if (!apb.psel) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (apb.penable) begin
                        if (cnt == 4'd1) begin
                            state       <= DONE;
                            cnt         <= '0;
                            apb.pready  <= 1'b1;
                            apb.prdata  <= rd_cap;
`ifdef APB_SLVERR_EN
                            apb.pslverr <= cap_err;
`endif
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    apb.pready  <= 1'b0;
                    apb.prdata  <= '0;
`ifdef APB_SLVERR_EN
                    apb.pslverr <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef APB_SLVERR_EN
    assign apb.pslverr = 1'b0;
`endif

    // Register storage: byte-strobed commit at the end of DONE, one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (state == DONE && cap_write && !cap_err) begin
                for (int unsigned b = 0; b < STRB_W; b++) begin
                    if (cap_strb[b]) begin
                        regs[cap_idx][b*8 +: 8] <= cap_wdata[b*8 +: 8];
                    end
                end
                reg_wr_pulse[cap_idx] <= 1'b1;
            end
        end
    end

    // Flatten the bank for the SNN core.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_W +: DATA_W] = regs[i];
        end
    end
endmodule

// File: tb/tb_apb4_slave_regbank.sv
// Bench for apb4_slave_regbank: two instances (no wait states / three wait
// states) share one stimulus bus gated by dsel. A transaction-level model
// predicts pready timing, read data, error flag, write pulses and register
// contents; a negedge process compares every cycle.
`timescale 1ns/1ps
module tb_apb4_slave_regbank;
    localparam int unsigned NREG  = 16;
    localparam logic [15:0] RO    = 16'h0008;
    localparam logic [31:0] RST_V = 32'hA5A5_0000;
    localparam int          WS_A  = 0;
    localparam int          WS_B  = 3;
`ifdef APB_SLVERR_EN
    localparam bit SLVERR = 1'b1;
`else
    localparam bit SLVERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NREG*32-1:0] hw, reg_q_a, reg_q_b;
    logic [NREG-1:0]    pulse_a, pulse_b;

    apb4_slave_regbank_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
    apb4_slave_regbank_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

    logic        b_psel, b_penable, b_pwrite;
    logic [31:0] b_paddr, b_pwdata;
    logic [3:0]  b_pstrb;
    int          dsel;

    assign ifa.psel    = b_psel && (dsel == 0);
    assign ifa.penable = b_penable && (dsel == 0);
    assign ifa.pwrite  = b_pwrite;
    assign ifa.paddr   = b_paddr;
    assign ifa.pwdata  = b_pwdata;
    assign ifa.pstrb   = b_pstrb;
    assign ifb.psel    = b_psel && (dsel == 1);
    assign ifb.penable = b_penable && (dsel == 1);
    assign ifb.pwrite  = b_pwrite;
    assign ifb.paddr   = b_paddr;
    assign ifb.pwdata  = b_pwdata;
    assign ifb.pstrb   = b_pstrb;

    logic        m_rdy, m_err;
    logic [31:0] m_rd;
    assign m_rdy = (dsel == 1) ? ifb.pready  : ifa.pready;
    assign m_rd  = (dsel == 1) ? ifb.prdata  : ifa.prdata;
    assign m_err = (dsel == 1) ? ifb.pslverr : ifa.pslverr;

    apb4_slave_regbank #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NREG), .WAIT_STATES(WS_A),
                         .RO_MASK(RO), .RESET_VAL(RST_V)) dut_a (
        .clk(clk), .rst(rst), .apb(ifa), .reg_q(reg_q_a),
        .reg_wr_pulse(pulse_a), .hw_status(hw));

    apb4_slave_regbank #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NREG), .WAIT_STATES(WS_B),
                         .RO_MASK(RO), .RESET_VAL(RST_V)) dut_b (
        .clk(clk), .rst(rst), .apb(ifb), .reg_q(reg_q_b),
        .reg_wr_pulse(pulse_b), .hw_status(hw));

    // Model state
    logic [31:0] mem [2][NREG];
    logic [15:0] exp_pulse [2];
    logic [15:0] pend_pulse [2];
    int          pend_idx [2];
    logic [31:0] pend_val [2];
    bit          exp_pready [2];
    logic [31:0] exp_rdata [2];
    bit          exp_err [2];
    bit          chk_en = 1'b0;

    int          n_vec = 0;
    int          n_bad = 0;
    int          obs_lat;
    logic [31:0] obs_rd;
    logic        obs_err;

    function automatic logic [31:0] hw_val(input int i);
        return 32'h5100_0000 + 32'(i);
    endfunction

    function automatic int ws(input int d);
        return (d == 0) ? WS_A : WS_B;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NREG; i++) mem[d][i] = RST_V;
            pend_pulse[d] = '0;
            exp_pulse[d]  = '0;
            exp_pready[d] = 1'b0;
            exp_rdata[d]  = '0;
            exp_err[d]    = 1'b0;
        end
    endtask

    // Advance one cycle; apply commits that land on this edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_pulse[d] = pend_pulse[d];
            if (pend_pulse[d] != '0) mem[d][pend_idx[d]] = pend_val[d];
            pend_pulse[d] = '0;
            exp_pready[d] = 1'b0;
            exp_rdata[d]  = '0;
            exp_err[d]    = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            b_psel    = 1'b0;
            b_penable = 1'b0;
        end
    endtask

    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int abort_at, input bit abort_rst, input int stall_at);
        int          idx;
        int          n_en;
        bit          legal;
        bit          fin;
        logic [31:0] merged;
        idx   = int'(addr >> 2);
        legal = (addr[1:0] == 2'b00) && (idx < NREG);
        if (legal && wr && RO[idx]) legal = 1'b0;
        obs_lat = 0;
        obs_rd  = '0;
        obs_err = 1'b0;
        tick();
        dsel = d; b_psel = 1'b1; b_penable = 1'b0; b_pwrite = wr;
        b_paddr = addr; b_pwdata = wdata; b_pstrb = strb;
        fin  = 1'b0;
        n_en = 0;
        for (int k = 1; k <= 20 && !fin; k++) begin
            tick();
            b_penable = 1'b1;
            if (k == abort_at) begin
                b_psel    = 1'b0;
                b_penable = 1'b0;
                fin       = 1'b1;
                if (abort_rst) begin
                    rst = 1'b1;
                    reset_model();
                end
            end else if (n_en == ws(d)) begin
                exp_pready[d] = 1'b1;
                exp_rdata[d]  = '0;
                if (legal && !wr) exp_rdata[d] = RO[idx] ? hw_val(idx) : mem[d][idx];
                exp_err[d] = !legal && SLVERR;
                if (legal && wr) begin
                    merged = mem[d][idx];
                    for (int b = 0; b < 4; b++) if (strb[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
                    pend_pulse[d]      = '0;
                    pend_pulse[d][idx] = 1'b1;
                    pend_idx[d]        = idx;
                    pend_val[d]        = merged;
                end
                fin = 1'b1;
            end else if (k == stall_at) begin
                b_penable = 1'b0;
            end else begin
                n_en++;
            end
            #2;
            if (obs_lat == 0 && m_rdy === 1'b1) begin
                obs_lat = k;
                obs_rd  = m_rd;
                obs_err = m_err;
            end
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    logic [NREG*32-1:0] c_q;
    logic [15:0]        c_p;
    logic               c_rdy, c_err;
    logic [31:0]        c_rd;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin
                    c_q = reg_q_a; c_p = pulse_a; c_rdy = ifa.pready; c_rd = ifa.prdata; c_err = ifa.pslverr;
                end else begin
                    c_q = reg_q_b; c_p = pulse_b; c_rdy = ifb.pready; c_rd = ifb.prdata; c_err = ifb.pslverr;
                end
                check($sformatf("pready[%0d]", d), 32'(c_rdy), 32'(exp_pready[d]));
                check($sformatf("prdata[%0d]", d), c_rd, exp_pready[d] ? exp_rdata[d] : 32'h0);
                check($sformatf("pslverr[%0d]", d), 32'(c_err), exp_pready[d] ? 32'(exp_err[d]) : 32'h0);
                check($sformatf("pulse[%0d]", d), 32'(c_p), 32'(exp_pulse[d]));
                for (int i = 0; i < NREG; i++) begin
                    if (!RO[i]) check($sformatf("reg_q[%0d][%0d]", d, i), c_q[i*32 +: 32], mem[d][i]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NREG; i++) hw[i*32 +: 32] = hw_val(i);
        b_psel = 1'b0; b_penable = 1'b0; b_pwrite = 1'b0;
        b_paddr = '0; b_pwdata = '0; b_pstrb = '0; dsel = 0;
        rst = 1'b1;
        reset_model();
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle(1);

        // Reset contents through reads on the zero-wait instance
        for (int i = 0; i < NREG; i++) begin
            xfer(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, 0, 1'b0, 0);
            if (i == 0) begin
                check("rst_rd_r0", obs_rd, 32'hA5A5_0000);
                check("lat_ws0", 32'(obs_lat), 32'd1);
            end
            if (i == 3) begin
                check("rst_rd_ro3", obs_rd, 32'h5100_0003);
                check("rst_rd_ro3_err", 32'(obs_err), 32'h0);
            end
        end
        xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0, 0, 1'b0, 0);
        check("rst_rd_b_ro3", obs_rd, 32'h5100_0003);
        idle(1);

        // Three wait states: write lands on ACCESS cycle 4
        xfer(1, 1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 0);
        check("lat_ws3", 32'(obs_lat), 32'd4);
        idle(1);
        #2;
        check("pulse_b_lit", 32'(pulse_b), 32'h0000_0004);
        check("regq_b2_lit", reg_q_b[95:64], 32'hDEAD_BEEF);
        xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, 0, 1'b0, 0);
        check("rd_b2_lit", obs_rd, 32'hDEAD_BEEF);

        // Byte strobes, back-to-back on the zero-wait instance
        xfer(0, 1'b1, 32'h10, 32'h1122_3344, 4'hF, 0, 1'b0, 0);
        xfer(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0100, 0, 1'b0, 0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 0);
        check("strb_lit", obs_rd, 32'h11BB_3344);
        xfer(0, 1'b1, 32'h10, 32'h5566_7788, 4'b1010, 0, 1'b0, 0);
        xfer(0, 1'b1, 32'h14, 32'hFFFF_FFFF, 4'h0, 0, 1'b0, 0);
        idle(1);
        #2;
        check("strb0_pulse_lit", 32'(pulse_a), 32'h0000_0020);
        check("strb0_val_lit", reg_q_a[191:160], 32'hA5A5_0000);

        // Illegal accesses: misaligned, out of range, read-only write, bad read
        xfer(0, 1'b1, 32'h41, 32'h1234_5678, 4'hF, 0, 1'b0, 0);
        check("err_misaligned", 32'(obs_err), 32'(SLVERR));
        xfer(0, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 0, 1'b0, 0);
        check("err_range", 32'(obs_err), 32'(SLVERR));
        xfer(0, 1'b1, 32'h0C, 32'h1234_5678, 4'hF, 0, 1'b0, 0);
        check("err_ro", 32'(obs_err), 32'(SLVERR));
        xfer(0, 1'b0, 32'h44, 32'h0, 4'h0, 0, 1'b0, 0);
        check("err_rd_data", obs_rd, 32'h0);
        xfer(1, 1'b1, 32'h0C, 32'h1234_5678, 4'hF, 0, 1'b0, 0);
        xfer(1, 1'b0, 32'h06, 32'h0, 4'h0, 0, 1'b0, 0);
        idle(1);

        // Abort in WAIT, then a normal transfer; then a penable stall
        xfer(1, 1'b1, 32'h18, 32'h1234_5678, 4'hF, 2, 1'b0, 0);
        check("abort_no_ready", 32'(obs_lat), 32'd0);
        idle(2);
        xfer(1, 1'b1, 32'h18, 32'hCAFE_F00D, 4'hF, 0, 1'b0, 0);
        xfer(1, 1'b0, 32'h18, 32'h0, 4'h0, 0, 1'b0, 0);
        check("after_abort_lit", obs_rd, 32'hCAFE_F00D);
        xfer(1, 1'b1, 32'h1C, 32'h0102_0304, 4'hF, 0, 1'b0, 2);
        check("stall_lat", 32'(obs_lat), 32'd5);

        // Reset in the middle of a write
        xfer(1, 1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, 0, 1'b0, 0);
        idle(1);
        xfer(1, 1'b1, 32'h24, 32'h5555_5555, 4'hF, 2, 1'b1, 0);
        tick();
        rst = 1'b0;
        #2;
        check("rst_mid_r8_lit", reg_q_b[287:256], 32'hA5A5_0000);
        check("rst_mid_r2_lit", reg_q_b[95:64], 32'hA5A5_0000);
        xfer(1, 1'b1, 32'h24, 32'h600D_CAFE, 4'hF, 0, 1'b0, 0);
        idle(1);
        xfer(1, 1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0, 0);
        check("after_rst_lit", obs_rd, 32'h600D_CAFE);
        idle(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
